serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial addition controller.
- Time-multiplexes one 1-bit adder cell across a WIDTH-bit addition, LSB first, one bit per clock. The cell is two half-adder stages plus an OR on the carries.
- Start/busy/done handshake.
- Holds the last result for downstream logic that cannot afford a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-position counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request to begin an addition; sampled only when accepted (see Behaviour).
- op_a  input  WIDTH  operand A; captured on the accepting edge.
- op_b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when result/carry_out become valid.
- result  output  WIDTH  sum, registered; holds until the next completion.
- carry_out  output  1  final carry, registered; holds with result.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediately, no clock needed):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0.
  - Internal shift registers, carry flop and counter cleared.
- States: IDLE, SHIFT, DONE. Moore outputs: busy=(state==SHIFT), done=(state==DONE).
- IDLE:
  - start=1 at edge k latches op_a, op_b into shift regs A/B, clears carry flop, count=0, state→SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each edge:
  - s = A[0]^B[0]^c; c' = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - s shifts into the MSB of accumulator S (S shifts right); A, B shift right; count++.
  - start is ignored; op_a/op_b changes have no effect.
- SHIFT exit: on the edge where count reaches WIDTH-1 (edge k+WIDTH):
  - result ← final S, carry_out ← c', state→DONE.
- DONE: lasts exactly one cycle; done=1, busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back, no bubble); else →IDLE.
- Latency and throughput:
  - start accepted at edge k → busy high for WIDTH cycles → done high in the cycle after edge k+WIDTH.
  - Throughput: one addition per WIDTH+1 cycles.
- Arithmetic: result = (op_a+op_b) mod 2^WIDTH; carry_out = bit WIDTH of the true sum.
- result/carry_out change only at the SHIFT→DONE edge; never partially updated.
- Reset mid-operation: everything returns to reset values; the aborted operation produces no done pulse.
- start held high continuously: a new operation begins every WIDTH+1 cycles.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on the accepting edge.
  - When sub=1: B is loaded as ~op_b and the carry flop is initialised to 1.
  - result = (op_a-op_b) mod 2^WIDTH; carry_out = 1 means no borrow (op_a≥op_b unsigned).
  - Timing identical to add.
- Undefined: no sub port; carry flop always initialised to 0; add only.

Test Plan (all WIDTH=8):
1. Reset, then start=1 with op_a=0x3C, op_b=0x0F → busy high 8 cycles; done pulse at edge k+9; result=0x4B, carry_out=0.
2. op_a=0xFF, op_b=0x01 → result=0x00, carry_out=1; result/carry_out hold after done until the next completion.
3. Start accepted with 0x10+0x20; at cycle 3 of busy, assert start with op_a=0xAA, op_b=0xAA → ignored; result=0x30, carry_out=0, exactly one done pulse.
4. start with 0x80+0x80; rst_n=0 asynchronously at cycle 4 of busy → busy, done, result, carry_out all 0 immediately; no done pulse after release.
5. start held high; ops 0x01+0x02 then 0x7F+0x01 → done pulses 9 cycles apart; results 0x03 then 0x80, carry_out 0 both.
6. SERIAL_ADD_SUB_EN defined, sub=1:
   - op_a=0x05, op_b=0x07 → result=0xFE, carry_out=0.
   - op_a=0x07, op_b=0x05 → result=0x02, carry_out=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell processes a WIDTH-bit add, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for subtraction.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_s, r_result;
  logic             r_c, r_carry_out;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_init;
  logic             w_ha1_s, w_ha1_c, w_ha2_s, w_ha2_c, w_carry;

  // Subtraction is A + ~B + 1, so only the B load and carry seed differ.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load = sub ? ~op_b : op_b;
  assign w_c_init = sub;
`else
  assign w_b_load = op_b;
  assign w_c_init = 1'b0;
`endif

  // Adder cell: two half adders plus an OR of their carries.
  assign w_ha1_s = r_a[0] ^ r_b[0];
  assign w_ha1_c = r_a[0] & r_b[0];
  assign w_ha2_s = w_ha1_s ^ r_c;
  assign w_ha2_c = w_ha1_s & r_c;
  assign w_carry = w_ha1_c | w_ha2_c;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_a   <= op_a;
      r_b   <= w_b_load;
      r_s   <= '0;
      r_c   <= w_c_init;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_s   <= {w_ha2_s, r_s[WIDTH-1:1]};
      r_c   <= w_carry;
      r_cnt <= r_cnt + CNT_W'(1);
      // Publish the whole sum at once so downstream never sees a partial value.
      if (w_last) begin
        r_result    <= {w_ha2_s, r_s[WIDTH-1:1]};
        r_carry_out <= w_carry;
      end
    end
  end

  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); define SERIAL_ADD_SUB_EN to cover subtraction.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  // One-cycle start pulse, then watch negedges until done (bounded).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int nbusy, output int done_at);
    nbusy = 0; done_at = -1;
    @(negedge clk); start = 1'b1; op_a = a; op_b = b;
    @(negedge clk); start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) nbusy++;
      if (done) begin done_at = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL rst_result: got %h want 00", result); end
    n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", carry_out); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    int nb, da;
    do_op(8'h3C, 8'h0F, nb, da);
    n_vec++; if (nb !== 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
    n_vec++; if (da !== 9) begin n_err++; $display("FAIL basic_done_at: got %0d want 9", da); end
    n_vec++; if (result !== 8'h4B) begin n_err++; $display("FAIL basic_result: got %h want 4b", result); end
    n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %b want 0", carry_out); end
  endtask

  task automatic test_hold;
    int nb, da;
    do_op(8'hFF, 8'h01, nb, da);
    n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL wrap_result: got %h want 00", result); end
    n_vec++; if (carry_out !== 1'b1) begin n_err++; $display("FAIL wrap_cout: got %b want 1", carry_out); end
    repeat (3) @(negedge clk);
    n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL hold_result: got %h want 00", result); end
    n_vec++; if (carry_out !== 1'b1) begin n_err++; $display("FAIL hold_cout: got %b want 1", carry_out); end
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_idle: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_patterns;
    logic [W-1:0] ta [4] = '{8'hAA, 8'hFF, 8'h80, 8'hC3};
    logic [W-1:0] tb [4] = '{8'h55, 8'hFF, 8'h7F, 8'h5A};
    logic [W-1:0] ts [4] = '{8'hFF, 8'hFE, 8'hFF, 8'h1D};
    logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int nb, da;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], nb, da);
      n_vec++; if (da !== 9 || result !== ts[i]) begin n_err++;
        $display("FAIL pat%0d_result: got %h (done_at %0d) want %h (done_at 9)", i, result, da, ts[i]); end
      n_vec++; if (carry_out !== tc[i]) begin n_err++;
        $display("FAIL pat%0d_cout: got %b want %b", i, carry_out, tc[i]); end
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    logic [W-1:0] r = 'x;
    logic c = 1'bx;
    @(negedge clk); start = 1'b1; op_a = 8'h10; op_b = 8'h20;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op_a = 8'hAA; op_b = 8'hAA;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ndone++; r = result; c = carry_out; end
      @(negedge clk);
    end
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
    n_vec++; if (r !== 8'h30) begin n_err++; $display("FAIL ign_result: got %h want 30", r); end
    n_vec++; if (c !== 1'b0) begin n_err++; $display("FAIL ign_cout: got %b want 0", c); end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    int nbusy = 0;
    @(negedge clk); start = 1'b1; op_a = 8'h80; op_b = 8'h80;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++;
      $display("FAIL mid_rst_flags: got busy=%b done=%b want 0/0", busy, done); end
    n_vec++; if (result !== 8'h00 || carry_out !== 1'b0) begin n_err++;
      $display("FAIL mid_rst_result: got %h/%b want 00/0", result, carry_out); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      @(negedge clk);
    end
    n_vec++; if (ndone !== 0 || nbusy !== 0) begin n_err++;
      $display("FAIL mid_after_release: got done=%0d busy=%0d cycles want 0/0", ndone, nbusy); end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int d1 = -1, d2 = -1;
    logic [W-1:0] r1 = 'x, r2 = 'x;
    logic c1 = 1'bx, c2 = 1'bx;
    @(negedge clk); start = 1'b1; op_a = 8'h01; op_b = 8'h02;
    @(negedge clk); op_a = 8'h7F; op_b = 8'h01;
    for (int i = 1; i <= 30; i++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = i; r1 = result; c1 = carry_out; end
        else begin d2 = i; r2 = result; c2 = carry_out; break; end
      end else if (ndone == 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++; if (d1 !== 9) begin n_err++; $display("FAIL b2b_first_done: got %0d want 9", d1); end
    n_vec++; if (d2 - d1 !== 9) begin n_err++; $display("FAIL b2b_spacing: got %0d want 9", d2 - d1); end
    n_vec++; if (r1 !== 8'h03 || c1 !== 1'b0) begin n_err++; $display("FAIL b2b_first_res: got %h/%b want 03/0", r1, c1); end
    n_vec++; if (r2 !== 8'h80 || c2 !== 1'b0) begin n_err++; $display("FAIL b2b_second_res: got %h/%b want 80/0", r2, c2); end
    repeat (2) @(negedge clk);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int nb, da;
    sub = 1'b1;
    do_op(8'h05, 8'h07, nb, da);
    n_vec++; if (da !== 9 || result !== 8'hFE || carry_out !== 1'b0) begin n_err++;
      $display("FAIL sub_borrow: got %h/%b (done_at %0d) want fe/0 (9)", result, carry_out, da); end
    do_op(8'h07, 8'h05, nb, da);
    n_vec++; if (result !== 8'h02 || carry_out !== 1'b1) begin n_err++;
      $display("FAIL sub_noborrow: got %h/%b want 02/1", result, carry_out); end
    sub = 1'b0;
    do_op(8'h07, 8'h05, nb, da);
    n_vec++; if (result !== 8'h0C || carry_out !== 1'b0) begin n_err++;
      $display("FAIL sub_off_add: got %h/%b want 0c/0", result, carry_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_hold();
    test_patterns();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
